// File: rtl/inst_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch front-end.
//   PC_W / INSTR_W  : address and instruction widths
//   INSTR_BYTES     : PC increment between sequential fetches
//   fetch_state_t   : fetch FSM state encoding
//   fetch_entry_t   : fetch-buffer entry {pc, instr}
package inst_fetch_unit_pkg;

  localparam int PC_W    = 32;
  localparam int INSTR_W = 32;
  localparam logic [PC_W-1:0] INSTR_BYTES = 32'd4;

  typedef enum logic [1:0] {
    S_SYNC = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_ERR  = 2'd3
  } fetch_state_t;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  function automatic logic pc_misaligned(input logic [PC_W-1:0] p);
    return p[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/inst_fetch_unit_if.sv
// Fetch-unit bus bundle: instruction memory request/response channel and
// the decode-side valid/ready channel.
//   master : the fetch unit (drives imem_req/addr, inst_valid/data/pc)
//   slave  : memory + decode side (drives imem_gnt/rvalid/rdata, inst_ready)
interface inst_fetch_unit_if;
  import inst_fetch_unit_pkg::*;

  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_gnt;
  logic               imem_rvalid;
  logic [INSTR_W-1:0] imem_rdata;

  logic               inst_valid;
  logic               inst_ready;
  logic [INSTR_W-1:0] inst_data;
  logic [PC_W-1:0]    inst_pc;

  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata,
    output inst_valid, inst_data, inst_pc,
    input  inst_ready
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata,
    input  inst_valid, inst_data, inst_pc,
    output inst_ready
  );

endinterface

// File: rtl/inst_fetch_unit_fifo.sv
// fetch_fifo: synchronous FIFO with flush.
//   CLK, RESET (async, active-low)
//   flush            : empties the FIFO, wins over push/pop
//   push, push_data  : write; ignored when full unless a pop happens too
//   pop              : read; ignored when empty
//   head_valid, head_data : oldest entry, held until popped
//   full             : count == DEPTH
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             head_valid,
  output logic [WIDTH-1:0] head_data,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [CW-1:0]    count;
  logic             pop_ok;
  logic             push_ok;

  assign head_valid = count != '0;
  assign full       = count == DEPTH_C;
  assign head_data  = mem[rd_ptr];
  assign pop_ok     = pop && head_valid;
  // A full FIFO can still accept a push when the head leaves the same cycle.
  assign push_ok    = push && (!full || pop_ok);

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      mem    <= '{default: '0};
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch front-end.
//   CLK, RESET (async, active-low)
//   pc             : current PC from the PC register
//   coming_pc      : registered next PC for the PC register
//   bus            : imem request/response + decode valid/ready (master side)
//   redirect_valid, redirect_pc : control-flow redirect from execute
//   fetch_err      : sticky misaligned-PC flag, cleared by a redirect
//
// state  | meaning
// S_SYNC | coming_pc just changed; wait one cycle for pc to settle
// S_REQ  | request imem at pc when the buffer has room
// S_WAIT | one request outstanding; waiting for rvalid
// S_ERR  | misaligned pc; idle until a redirect
module inst_fetch_unit
  import inst_fetch_unit_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC   = 32'h0000_0000,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic [PC_W-1:0] pc,
  output logic [PC_W-1:0] coming_pc,
  inst_fetch_unit_if.master bus,
  input  logic            redirect_valid,
  input  logic [PC_W-1:0] redirect_pc,
  output logic            fetch_err
);

  fetch_state_t    state;
  logic [PC_W-1:0] req_pc;
  logic            drop;
  logic            misaligned;
  logic            fifo_full;
  logic            fifo_push;
  logic            fifo_valid;
  fetch_entry_t    push_entry;
  fetch_entry_t    head_entry;

  assign misaligned    = pc_misaligned(pc);
  assign bus.imem_req  = (state == S_REQ) && !fifo_full && !misaligned && !redirect_valid;
  assign bus.imem_addr = pc;

  // A response tagged by drop belongs to a fetch made before a redirect.
  assign fifo_push  = (state == S_WAIT) && bus.imem_rvalid && !drop && !redirect_valid;
  assign push_entry = '{pc: req_pc, instr: bus.imem_rdata};

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state     <= S_SYNC;
      coming_pc <= RESET_PC;
      req_pc    <= '0;
      drop      <= 1'b0;
      fetch_err <= 1'b0;
    end else if (redirect_valid) begin
      coming_pc <= redirect_pc;
      fetch_err <= 1'b0;
      if (state == S_WAIT && !bus.imem_rvalid) begin
        // Keep waiting so the stale response is swallowed, not mistaken
        // for the answer to the redirected fetch.
        drop  <= 1'b1;
        state <= S_WAIT;
      end else begin
        drop  <= 1'b0;
        state <= S_SYNC;
      end
    end else begin
      case (state)
        S_SYNC: begin
          if (misaligned) begin
            fetch_err <= 1'b1;
            state     <= S_ERR;
          end else begin
            state <= S_REQ;
          end
        end
        S_REQ: begin
          if (misaligned) begin
            fetch_err <= 1'b1;
            state     <= S_ERR;
          end else if (bus.imem_req && bus.imem_gnt) begin
            req_pc    <= pc;
            coming_pc <= pc + INSTR_BYTES;
            state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (bus.imem_rvalid) begin
            drop  <= 1'b0;
            state <= drop ? S_SYNC : S_REQ;
          end
        end
        S_ERR: state <= S_ERR;
        default: state <= S_SYNC;
      endcase
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(fetch_entry_t))
  ) u_fifo (
    .CLK        (CLK),
    .RESET      (RESET),
    .flush      (redirect_valid),
    .push       (fifo_push),
    .push_data  (push_entry),
    .pop        (fifo_valid && bus.inst_ready),
    .head_valid (fifo_valid),
    .head_data  (head_entry),
    .full       (fifo_full)
  );

  assign bus.inst_valid = fifo_valid;
  assign bus.inst_data  = head_entry.instr;
  assign bus.inst_pc    = head_entry.pc;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Testbench for inst_fetch_unit: acts as PC register, instruction memory and
// decode, and compares the DUT with a transaction-level model of the fetch
// stream (expected PC sequence, queue of words owed to decode).
module tb_inst_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int          DEPTH  = 2;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [31:0] pc;
  logic [31:0] coming_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fetch_err;

  inst_fetch_unit_if bus ();

  inst_fetch_unit #(.RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH)) dut (
    .CLK            (CLK),
    .RESET          (RESET),
    .pc             (pc),
    .coming_pc      (coming_pc),
    .bus            (bus),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fetch_err      (fetch_err)
  );

  always #5 CLK = ~CLK;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  // stimulus knobs
  int k_gnt = 100, k_rdy = 100, k_dmin = 1, k_dmax = 1;
  bit k_rand_data = 0;

  // memory state
  bit          m_out, m_killed;
  int          m_cnt;
  logic [31:0] m_addr, m_data;

  // reference model
  logic [31:0] q_pc[$];
  logic [31:0] q_dat[$];
  logic [31:0] exp_next, exp_cpc;
  bit          err_exp, sync_ready;

  function automatic bit pct(input int p);
    return $urandom_range(99, 0) < p;
  endfunction

  task automatic model_reset();
    q_pc.delete();
    q_dat.delete();
    m_out      = 0;
    m_killed   = 0;
    exp_next   = RST_PC;
    exp_cpc    = RST_PC;
    err_exp    = 0;
    sync_ready = 1;
  endtask

  // One clock. rmode: 0 none, 1 always, 2 only while a fetch is in flight
  // with no response this cycle, 3 only with a response this cycle and
  // words buffered, 4 random.
  task automatic cycle(input int rmode, input logic [31:0] rtgt, input bit stale,
                       output bit did_redir);
    bit fire, r, exp_req, req_s, gnt_s, rdy_s, v_s, old_sync;
    @(negedge CLK);
    pc   = coming_pc;
    fire = m_out && (m_cnt == 1);
    bus.imem_rvalid = fire || stale;
    bus.imem_rdata  = fire ? m_data : $urandom;
    gnt_s = pct(k_gnt);
    rdy_s = pct(k_rdy);
    bus.imem_gnt   = gnt_s;
    bus.inst_ready = rdy_s;
    case (rmode)
      1:       r = 1;
      2:       r = m_out && !fire;
      3:       r = fire && (q_pc.size() > 0);
      4:       r = pct(8);
      default: r = 0;
    endcase
    redirect_valid = r;
    redirect_pc    = rtgt;
    did_redir      = r;
    #1;
    exp_req = !m_out && !sync_ready && !err_exp && (exp_next[1:0] == 2'b00)
              && (q_pc.size() < DEPTH) && !r;
    chk("imem_req", {31'b0, bus.imem_req}, {31'b0, exp_req});
    if (bus.imem_req) chk("imem_addr", bus.imem_addr, exp_next);
    chk("inst_valid", {31'b0, bus.inst_valid}, {31'b0, q_pc.size() != 0});
    if (bus.inst_valid && q_pc.size() != 0) begin
      chk("inst_pc", bus.inst_pc, q_pc[0]);
      chk("inst_data", bus.inst_data, q_dat[0]);
    end
    req_s = bus.imem_req;
    v_s   = bus.inst_valid;
    @(posedge CLK);
    #1;
    old_sync = sync_ready;
    if (old_sync && !r) begin
      if (exp_next[1:0] != 2'b00) err_exp = 1;
      sync_ready = 0;
    end
    if (v_s && rdy_s && !r && q_pc.size() > 0) begin
      void'(q_pc.pop_front());
      void'(q_dat.pop_front());
    end
    if (fire) begin
      m_out = 0;
      if (m_killed) sync_ready = 1;
      else if (!r) begin
        q_pc.push_back(m_addr);
        q_dat.push_back(m_data);
      end
    end else if (m_out) begin
      m_cnt--;
    end
    if (req_s && gnt_s) begin
      m_out    = 1;
      m_killed = 0;
      m_addr   = exp_next;
      m_cnt    = $urandom_range(k_dmax, k_dmin);
      m_data   = k_rand_data ? $urandom : (exp_next ^ 32'hA5A5_0000);
      exp_next = exp_next + 32'd4;
      exp_cpc  = exp_next;
    end
    if (r) begin
      q_pc.delete();
      q_dat.delete();
      exp_next = rtgt;
      exp_cpc  = rtgt;
      err_exp  = 0;
      if (m_out) begin
        m_killed   = 1;
        sync_ready = 0;
      end else begin
        sync_ready = 1;
      end
    end
    chk("coming_pc", coming_pc, exp_cpc);
    chk("fetch_err", {31'b0, fetch_err}, {31'b0, err_exp});
  endtask

  task automatic run(input int n, input int rmode, input logic [31:0] rtgt);
    bit d;
    for (int i = 0; i < n; i++) cycle(rmode, rtgt, 0, d);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_coming_pc"}, coming_pc, RST_PC);
    chk({tag, "_imem_req"}, {31'b0, bus.imem_req}, 32'd0);
    chk({tag, "_inst_valid"}, {31'b0, bus.inst_valid}, 32'd0);
    chk({tag, "_inst_data"}, bus.inst_data, 32'd0);
    chk({tag, "_inst_pc"}, bus.inst_pc, 32'd0);
    chk({tag, "_fetch_err"}, {31'b0, fetch_err}, 32'd0);
  endtask

  initial begin
    bit hit;
    logic [31:0] tgt;
    RESET = 1'b0;
    pc = RST_PC;
    redirect_valid = 0;
    redirect_pc = '0;
    bus.imem_gnt = 0;
    bus.imem_rvalid = 0;
    bus.imem_rdata = '0;
    bus.inst_ready = 0;
    model_reset();
    repeat (3) @(posedge CLK);
    #1;
    check_reset_outputs("rst");
    RESET = 1'b1;

    // sequential fetch, always granted, 1-cycle memory
    run(14, 0, '0);

    // decode stalled: buffer fills, fetch stops, then drains in order
    k_rdy = 0;
    run(16, 0, '0);
    k_rdy = 100;
    run(10, 0, '0);

    // redirect while waiting on a slow response
    k_dmin = 3; k_dmax = 3;
    hit = 0;
    for (int i = 0; i < 40 && !hit; i++) cycle(2, 32'h100, 0, hit);
    chk("redir_wait_hit", {31'b0, hit}, 32'd1);
    run(12, 0, '0);

    // redirect in the same cycle as a response, with words buffered
    k_dmin = 1; k_dmax = 1; k_rdy = 0;
    hit = 0;
    for (int i = 0; i < 40 && !hit; i++) cycle(3, 32'h40, 0, hit);
    chk("redir_rvalid_hit", {31'b0, hit}, 32'd1);
    k_rdy = 100;
    run(8, 0, '0);

    // misaligned target, then recovery
    run(1, 1, 32'h102);
    run(8, 0, '0);
    run(1, 1, 32'h200);
    run(8, 0, '0);

    // address wrap
    run(1, 1, 32'hFFFF_FFF8);
    run(10, 0, '0);

    // asynchronous reset in the middle of a wait, then a stale rvalid
    k_dmin = 3; k_dmax = 3;
    hit = 0;
    for (int i = 0; i < 20 && !m_out; i++) cycle(0, '0, 0, hit);
    chk("mid_reset_inflight", {31'b0, m_out}, 32'd1);
    @(negedge CLK);
    #2;
    RESET = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    model_reset();
    pc = coming_pc;
    @(posedge CLK);
    #1;
    RESET = 1'b1;
    cycle(0, '0, 1, hit);
    run(10, 0, '0);

    // randomized traffic with random redirects
    k_rand_data = 1;
    for (int blk = 0; blk < 12; blk++) begin
      k_gnt  = $urandom_range(100, 30);
      k_rdy  = $urandom_range(100, 20);
      k_dmin = $urandom_range(2, 1);
      k_dmax = k_dmin + $urandom_range(2, 0);
      for (int i = 0; i < 200; i++) begin
        tgt = ($urandom & 32'h0000_0FFC) | (pct(15) ? 32'd2 : 32'd0);
        if (pct(3)) tgt = 32'hFFFF_FFF4;
        cycle(4, tgt, 0, hit);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
